// File: rtl/des_key_schedule.sv
// Iterative DES round-key generator.
// A 64-bit key is reduced by PC-1 into the 28-bit C and D halves at start.
// Each advance rotates both halves once more, and PC-2 of the current halves
// is presented to the round engine. Encrypt order rotates left (K1..K16) and
// decrypt order rotates right (K16..K1), so the 16 keys are never stored.
// Handshake: round_key_valid_dout is high for as long as a key is presented.
// The engine pulses advance_din for one cycle per key it consumes. The next
// key appears on the following cycle, so one key per cycle is possible.
// Bit 0 of every ascending-range vector is the FIPS bit 1 (the MSB).
module des_key_schedule (
  input  logic        clk,
  input  logic        reset,
  input  logic [0:63] key_din,
  input  logic        start_strobe_din,
  input  logic        decrypt_din,
  input  logic        advance_din,
  output logic [0:47] round_key_dout,
  output logic        round_key_valid_dout,
  output logic [3:0]  round_index_dout,
  output logic        busy_dout,
  output logic        done_dout
);

  typedef enum logic {s_idle, s_active} state_t;

  // FIPS 46-3 permuted choice 1, entries are 1-based key bit numbers.
  localparam logic [6:0] pc1_tab [0:55] = '{
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,
    7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18, 7'd10, 7'd2,
    7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,
    7'd60, 7'd52, 7'd44, 7'd36,
    7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7,
    7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22, 7'd14, 7'd6,
    7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,
    7'd28, 7'd20, 7'd12, 7'd4
  };

  // FIPS 46-3 permuted choice 2, entries are 1-based C||D bit numbers.
  localparam logic [5:0] pc2_tab [0:47] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28,
    6'd15, 6'd6,  6'd21, 6'd10, 6'd23, 6'd19, 6'd12, 6'd4,
    6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40,
    6'd51, 6'd45, 6'd33, 6'd48, 6'd44, 6'd49, 6'd39, 6'd56,
    6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  state_t      state;
  logic [0:27] c_reg;
  logic [0:27] d_reg;
  logic [4:0]  count;
  logic        mode;
  logic        done_reg;

  logic [0:55] pc1_out;
  logic [0:55] cd;
  logic [0:47] pc2_out;
  logic [4:0]  next_count;
  logic        shift_two;
  logic [4:0]  index_full;
  logic        active;
  logic        unused_bits;

  // Rotations toward bit 0 (left) or away from it (right), by 1 or 2 places.
  function automatic logic [0:27] rotl(input logic [0:27] v, input logic two);
    return two ? {v[2:27], v[0:1]} : {v[1:27], v[0]};
  endfunction

  function automatic logic [0:27] rotr(input logic [0:27] v, input logic two);
    return two ? {v[26:27], v[0:25]} : {v[27], v[0:26]};
  endfunction

  // PC-1 of the incoming key; the parity bits are never selected.
  always_comb begin
    pc1_out = '0;
    for (int j = 0; j < 56; j++) begin
      pc1_out[j] = key_din[6'(pc1_tab[j] - 7'd1)];
    end
  end

  // PC-2 of the current halves, from registers only.
  always_comb begin
    cd      = {c_reg, d_reg};
    pc2_out = '0;
    for (int j = 0; j < 48; j++) begin
      pc2_out[j] = cd[pc2_tab[j] - 6'd1];
    end
  end

  // Steps 2, 9 and 16 move by one place in both directions, because the
  // decrypt table shift[18-n] hits the single-shift rounds at the same steps.
  always_comb begin
    next_count = count + 5'd1;
    shift_two  = !(next_count == 5'd2 || next_count == 5'd9 ||
                   next_count == 5'd16);
  end

  // Schedule state machine: load on start, rotate on each advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= s_idle;
      c_reg    <= '0;
      d_reg    <= '0;
      count    <= '0;
      mode     <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        s_idle: begin
          if (start_strobe_din) begin
            // Decrypt starts from C16D16, which equals C0D0.
            c_reg <= decrypt_din ? pc1_out[0:27]  : rotl(pc1_out[0:27], 1'b0);
            d_reg <= decrypt_din ? pc1_out[28:55] : rotl(pc1_out[28:55], 1'b0);
            mode  <= decrypt_din;
            count <= 5'd1;
            state <= s_active;
          end
        end
        s_active: begin
          if (advance_din) begin
            if (count == 5'd16) begin
              count    <= '0;
              done_reg <= 1'b1;
              state    <= s_idle;
            end else begin
              count <= next_count;
              c_reg <= mode ? rotr(c_reg, shift_two) : rotl(c_reg, shift_two);
              d_reg <= mode ? rotr(d_reg, shift_two) : rotl(d_reg, shift_two);
            end
          end
        end
        default: state <= s_idle;
      endcase
    end
  end

  // Round 16 wraps to 0 on the 4-bit index; valid tells it apart from idle.
  assign active               = (state == s_active);
  assign index_full           = mode ? (5'd17 - count) : count;
  assign round_key_dout       = active ? pc2_out : '0;
  assign round_key_valid_dout = active;
  assign busy_dout            = active;
  assign round_index_dout     = active ? index_full[3:0] : 4'd0;
  assign done_dout            = done_reg;

  assign unused_bits = ^{key_din[7], key_din[15], key_din[23], key_din[31],
                         key_din[39], key_din[47], key_din[55], key_din[63],
                         index_full[4]};

endmodule
